// File: rtl/twin_reg_pkg.sv
// Shared definitions for the twin (active/shadow) register bank:
// bank-operation encoding, counter width and a saturating increment.
package twin_reg_pkg;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_ROT    = 2'd1,
        OP_COMMIT = 2'd2,
        OP_SWAP   = 2'd3
    } op_t;

    localparam int CNT_W = 8;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/twin_register_bank_channel.sv
// One channel of the twin bank: its active/shadow register pair and dirty flag.
// The decoded bank operation is applied first; a same-cycle write then overrides the shadow.
module twin_reg_channel
    import twin_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  op_t              op,
    input  logic             write,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] neighbour,
    output logic [WIDTH-1:0] active,
    output logic             dirty
);

    logic [WIDTH-1:0] shadow;

    // Later non-blocking writes win, so a write lands after commit/swap in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= RST_VAL;
            shadow <= RST_VAL;
            dirty  <= 1'b0;
        end else begin
            unique case (op)
                OP_SWAP: begin
                    active <= shadow;
                    shadow <= active;
                    dirty  <= 1'b0;
                end
                OP_COMMIT: begin
                    active <= shadow;
                    dirty  <= 1'b0;
                end
                OP_ROT:  active <= neighbour;
                default: ;
            endcase
            if (write) begin
                shadow <= wr_data;
                dirty  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/twin_register_bank.sv
// Multi-channel active/shadow register bank with atomic commit/swap, rotate
// and a saturating count of bank updates.
module twin_register_bank
    import twin_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               NUM_CH  = 2,
    parameter int               CH_W    = $clog2(NUM_CH),
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    commit,
    input  logic                    swap,
    input  logic                    rot_en,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       dirty,
    output logic [CNT_W-1:0]        commit_cnt
);

    op_t op;

    // Lower-priority operations are dropped, never deferred.
    always_comb begin
        op = OP_NONE;
        if (swap)        op = OP_SWAP;
        else if (commit) op = OP_COMMIT;
        else if (rot_en) op = OP_ROT;
    end

    // Out-of-range channel selects match no instance, so the write is ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int PREV = (i + NUM_CH - 1) % NUM_CH;

        twin_reg_channel #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .op        (op),
            .write     (wr_en && (wr_ch == CH_W'(i))),
            .wr_data   (wr_data),
            .neighbour (q[PREV*WIDTH +: WIDTH]),
            .active    (q[i*WIDTH +: WIDTH]),
            .dirty     (dirty[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)                 commit_cnt <= '0;
        else if (swap || commit) commit_cnt <= sat_inc(commit_cnt);
    end

endmodule

// File: tb/tb_twin_register_bank.sv
// Directed self-checking bench for twin_register_bank: a 2-channel instance for
// the main sequence plus 4- and 3-channel instances for rotate and range cases.
module tb_twin_register_bank;

    logic        clk;
    logic        rst;

    logic        wr_en, commit, swap, rot_en;
    logic [0:0]  wr_ch;
    logic [7:0]  wr_data;
    logic [15:0] q;
    logic [1:0]  dirty;
    logic [7:0]  commit_cnt;

    logic        wr_en4, commit4, rot_en4;
    logic [1:0]  wr_ch4;
    logic [7:0]  wr_data4;
    logic [31:0] q4;
    logic [3:0]  dirty4;
    logic [7:0]  commit_cnt4;

    logic        wr_en3, commit3;
    logic [1:0]  wr_ch3;
    logic [7:0]  wr_data3;
    logic [23:0] q3;
    logic [2:0]  dirty3;
    logic [7:0]  commit_cnt3;

    int checks   = 0;
    int failures = 0;

    twin_register_bank #(.WIDTH(8), .NUM_CH(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .commit(commit), .swap(swap), .rot_en(rot_en),
        .q(q), .dirty(dirty), .commit_cnt(commit_cnt)
    );

    twin_register_bank #(.WIDTH(8), .NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_ch(wr_ch4), .wr_data(wr_data4),
        .commit(commit4), .swap(1'b0), .rot_en(rot_en4),
        .q(q4), .dirty(dirty4), .commit_cnt(commit_cnt4)
    );

    twin_register_bank #(.WIDTH(8), .NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
        .commit(commit3), .swap(1'b0), .rot_en(1'b0),
        .q(q3), .dirty(dirty3), .commit_cnt(commit_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic apply_stimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic write2(input logic ch, input logic [7:0] data);
        wr_en = 1'b1; wr_ch = ch; wr_data = data;
        apply_stimulus(1);
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 0; wr_ch = '0; wr_data = '0; commit = 0; swap = 0; rot_en = 0;
        wr_en4 = 0; wr_ch4 = '0; wr_data4 = '0; commit4 = 0; rot_en4 = 0;
        wr_en3 = 0; wr_ch3 = '0; wr_data3 = '0; commit3 = 0;
        apply_stimulus(1);

        $display("[TB] reset");
        rst = 1'b1;
        apply_stimulus(1);
        rst = 1'b0;
        check_output("reset_q", 32'(q), 32'h0000);
        check_output("reset_dirty", 32'(dirty), 32'h0);
        check_output("reset_cnt", 32'(commit_cnt), 32'd0);

        $display("[TB] 4-channel rotate");
        for (int i = 0; i < 4; i++) begin
            wr_en4 = 1'b1; wr_ch4 = 2'(i); wr_data4 = 8'(8'h11 * (i + 1));
            apply_stimulus(1);
        end
        wr_en4 = 1'b0;
        check_output("ch4_dirty_after_writes", 32'(dirty4), 32'hF);
        commit4 = 1'b1;
        apply_stimulus(1);
        commit4 = 1'b0;
        check_output("ch4_commit_q", q4, 32'h44332211);
        rot_en4 = 1'b1;
        apply_stimulus(1);
        rot_en4 = 1'b0;
        check_output("ch4_rotate_q", q4, 32'h33221144);
        check_output("ch4_rotate_cnt", 32'(commit_cnt4), 32'd1);
        commit4 = 1'b1;
        apply_stimulus(1);
        commit4 = 1'b0;
        check_output("ch4_shadow_kept_by_rotate", q4, 32'h44332211);

        $display("[TB] 3-channel out-of-range write");
        for (int i = 0; i < 3; i++) begin
            wr_en3 = 1'b1; wr_ch3 = 2'(i); wr_data3 = 8'(8'h11 * (i + 1));
            apply_stimulus(1);
        end
        wr_en3 = 1'b0;
        commit3 = 1'b1;
        apply_stimulus(1);
        commit3 = 1'b0;
        check_output("ch3_commit_q", 32'(q3), 32'h332211);
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 8'hFF;
        apply_stimulus(1);
        wr_en3 = 1'b0;
        check_output("ch3_oob_dirty", 32'(dirty3), 32'h0);
        commit3 = 1'b1;
        apply_stimulus(1);
        commit3 = 1'b0;
        check_output("ch3_oob_shadow", 32'(q3), 32'h332211);

        $display("[TB] load and commit");
        write2(1'b0, 8'hAA);
        write2(1'b1, 8'h55);
        check_output("load_q_unchanged", 32'(q), 32'h0000);
        check_output("load_dirty", 32'(dirty), 32'h3);
        commit = 1'b1;
        apply_stimulus(1);
        commit = 1'b0;
        check_output("commit_q", 32'(q), 32'h55AA);
        check_output("commit_dirty", 32'(dirty), 32'h0);
        check_output("commit_cnt1", 32'(commit_cnt), 32'd1);

        $display("[TB] swap");
        write2(1'b0, 8'h0F);
        check_output("swap_pre_dirty", 32'(dirty), 32'h1);
        swap = 1'b1;
        apply_stimulus(1);
        check_output("swap1_q", 32'(q), 32'h550F);
        check_output("swap1_cnt", 32'(commit_cnt), 32'd2);
        check_output("swap1_dirty", 32'(dirty), 32'h0);
        apply_stimulus(1);
        swap = 1'b0;
        check_output("swap2_q", 32'(q), 32'h55AA);

        $display("[TB] rotate");
        rot_en = 1'b1;
        apply_stimulus(1);
        check_output("rot1_q", 32'(q), 32'hAA55);
        apply_stimulus(1);
        rot_en = 1'b0;
        check_output("rot2_q", 32'(q), 32'h55AA);
        check_output("rot_cnt", 32'(commit_cnt), 32'd3);

        $display("[TB] simultaneous events");
        swap = 1'b1; commit = 1'b1; rot_en = 1'b1;
        apply_stimulus(1);
        swap = 1'b0; commit = 1'b0; rot_en = 1'b0;
        check_output("priority_q", 32'(q), 32'h550F);
        check_output("priority_cnt", 32'(commit_cnt), 32'd4);

        commit = 1'b1; wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'h77;
        apply_stimulus(1);
        commit = 1'b0; wr_en = 1'b0;
        check_output("commit_write_q", 32'(q), 32'h55AA);
        check_output("commit_write_dirty", 32'(dirty), 32'h2);
        commit = 1'b1;
        apply_stimulus(1);
        commit = 1'b0;
        check_output("commit_write_shadow", 32'(q), 32'h77AA);
        check_output("commit_write_cnt", 32'(commit_cnt), 32'd6);

        rot_en = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'h33;
        apply_stimulus(1);
        rot_en = 1'b0; wr_en = 1'b0;
        check_output("rot_write_q", 32'(q), 32'hAA77);
        check_output("rot_write_dirty", 32'(dirty), 32'h1);
        apply_stimulus(1);
        check_output("idle_q", 32'(q), 32'hAA77);
        check_output("idle_dirty", 32'(dirty), 32'h1);
        check_output("idle_cnt", 32'(commit_cnt), 32'd6);

        swap = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'hC3;
        apply_stimulus(1);
        swap = 1'b0; wr_en = 1'b0;
        check_output("swap_write_q", 32'(q), 32'h7733);
        check_output("swap_write_dirty", 32'(dirty), 32'h1);
        commit = 1'b1;
        apply_stimulus(1);
        commit = 1'b0;
        check_output("swap_write_shadow", 32'(q), 32'hAAC3);
        check_output("swap_write_cnt", 32'(commit_cnt), 32'd8);

        $display("[TB] saturation");
        commit = 1'b1;
        apply_stimulus(246);
        check_output("sat_cnt254", 32'(commit_cnt), 32'd254);
        apply_stimulus(1);
        check_output("sat_cnt255", 32'(commit_cnt), 32'd255);
        apply_stimulus(53);
        commit = 1'b0;
        check_output("sat_hold", 32'(commit_cnt), 32'd255);

        $display("[TB] reset mid-operation");
        rst = 1'b1; commit = 1'b1; swap = 1'b1; rot_en = 1'b1;
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'hEE;
        apply_stimulus(1);
        rst = 1'b0; commit = 1'b0; swap = 1'b0; rot_en = 1'b0; wr_en = 1'b0;
        check_output("midrst_q", 32'(q), 32'h0000);
        check_output("midrst_dirty", 32'(dirty), 32'h0);
        check_output("midrst_cnt", 32'(commit_cnt), 32'd0);
        commit = 1'b1;
        apply_stimulus(1);
        commit = 1'b0;
        check_output("midrst_shadow", 32'(q), 32'h0000);
        check_output("midrst_cnt_after", 32'(commit_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twin_register_bank.md
Name: twin_register_bank

Overview:
- Parametrised, multi-channel successor to the fixed two-channel 8-bit register pair.
- Holds NUM_CH channels of WIDTH bits in an active bank, which drives the outputs, and a shadow bank, which is staged by writes.
- Shadow contents move to the active bank atomically on commit or swap. The active bank can also be rotated across channels.
- Sits between a configuration/control source and downstream datapaths that need glitch-free, simultaneous update of all channels.

Parameters:
- WIDTH, 8, bits per channel
- NUM_CH, 2, number of channels (>=2)
- CH_W, $clog2(NUM_CH), width of the channel select
- RST_VAL, 0, reset value of every active and shadow register

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write wr_data into shadow channel wr_ch
- wr_ch  input  CH_W  shadow channel select
- wr_data  input  WIDTH  write data
- commit  input  1  copy the whole shadow bank into the active bank
- swap  input  1  exchange the active and shadow banks
- rot_en  input  1  rotate the active bank by one channel
- q  output  NUM_CH*WIDTH  active bank, flat; channel i at bits [i*WIDTH +: WIDTH]
- dirty  output  NUM_CH  per-channel flag: shadow written since last commit/swap
- commit_cnt  output  8  saturating count of commits plus swaps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset: on a clk edge with rst=1, all active and shadow channels take RST_VAL, dirty=0 and commit_cnt=0. rst overrides every other input, including mid-operation.
- Latency: all outputs are registered, with 1-cycle latency from the input edge. No combinational input-to-output path.
- Write: wr_en=1 with wr_ch<NUM_CH sets shadow[wr_ch]<=wr_data and dirty[wr_ch]<=1. With wr_ch>=NUM_CH (NUM_CH not a power of 2) the write is ignored and no flag changes.
- Commit: active[i]<=shadow[i] for all i, dirty<=0, commit_cnt increments. The shadow is unchanged.
- Swap: active[i]<=shadow[i] and shadow[i]<=active[i] for all i, dirty<=0, commit_cnt increments.
- Rotate: active[i]<=active[i-1] for i>0, and active[0]<=active[NUM_CH-1]. The shadow and dirty flags are unchanged.
- Priority of bank operations in one cycle: swap > commit > rotate. A lower-priority operation is dropped, not deferred.
- Write in the same cycle as commit or swap:
  - Commit and swap use the pre-edge shadow values.
  - The write then lands in shadow[wr_ch] after the bank operation. With swap, the written channel gets wr_data, not the old active value.
  - dirty ends as a one-hot at wr_ch.
- Write in the same cycle as rotate: both take effect independently.
- commit_cnt saturates at 255 and does not wrap.
- Idle: with no enables asserted, all state holds.
- Internal state machine: none beyond the registers. The behaviour is a priority-encoded next-state selection per bank.

Decomposition:
- Shared package twin_reg_pkg holds:
  - the operation encoding enum (OP_NONE, OP_ROT, OP_COMMIT, OP_SWAP)
  - the CNT_W=8 constant
  - a saturating-increment function
- One natural sub-module, twin_reg_channel: a single channel's active/shadow pair plus its dirty bit. It takes the decoded operation, a local write strobe, and the neighbour active value for rotate. The top level generates NUM_CH instances and holds the priority decode and commit_cnt.

Test Plan:
- Reset, then load (NUM_CH=2, WIDTH=8): rst=1 for 1 cycle -> q=0x0000, dirty=0, cnt=0. Write ch0=0xAA and ch1=0x55 -> q stays 0x0000, dirty=2'b11. Commit -> q=0x55AA, dirty=0, cnt=1.
- Swap: from q=0x55AA and shadow=0x55AA, write ch0=0x0F, then swap -> q=0x550F, shadow=0x55AA, cnt=2. Swap again -> q=0x55AA.
- Rotate: q=0x55AA, rot_en=1 for 1 cycle -> q=0xAA55. Two rotates in total -> back to 0x55AA. NUM_CH=4 with 0x44332211 -> q=0x33221144.
- Simultaneous events:
  - swap+commit+rot in one cycle -> only the swap occurs.
  - commit and a write ch1=0x77 in one cycle -> active ch1 gets the old shadow value, shadow ch1=0x77, dirty=2'b10.
- Saturation and range: 300 commits -> cnt=255. NUM_CH=3 with wr_ch=3 -> no change to shadow or dirty.
- Reset mid-operation: rst=1 together with commit, swap and wr_en -> all registers RST_VAL, cnt=0 on the next cycle.
